// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller.
//   state_e     : FSM state codes exported on the state port
//   OP_*        : instruction opcodes (Instruction[31:26])
//   ALU_*       : alu_op classes
//   PC_*        : pc_source selects
//   SRCB_*      : alu_src_b selects
//   ctrl_t      : bundle of datapath strobes/selects driven by the FSM
package mips_pkg;

   localparam int unsigned STATE_W  = 4;
   localparam int unsigned OPCODE_W = 6;
   localparam int unsigned SEL_W    = 2;
   localparam int unsigned COUNT_W  = 32;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_FAULT  = 4'd15
   } state_e;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

   localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
   localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
   localparam logic [SEL_W-1:0] ALU_FUNCT = 2'b10;

   localparam logic [SEL_W-1:0] PC_ALU    = 2'b00;
   localparam logic [SEL_W-1:0] PC_ALUOUT = 2'b01;
   localparam logic [SEL_W-1:0] PC_JUMP   = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_RT      = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
   localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

   typedef struct packed {
      logic             pc_write;
      logic             pc_write_cond;
      logic             i_or_d;
      logic             mem_read;
      logic             mem_write;
      logic             ir_write;
      logic             mem_to_reg;
      logic             reg_dst;
      logic             reg_write;
      logic             alu_src_a;
      logic [SEL_W-1:0] alu_src_b;
      logic [SEL_W-1:0] alu_op;
      logic [SEL_W-1:0] pc_source;
   } ctrl_t;

   // States in which the FSM stalls on the unified memory.
   function automatic logic is_mem_wait_state(input state_e s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage : mips_pkg

// File: rtl/mem_watchdog.sv
// Memory wait watchdog: counts cycles spent stalled on memory and flags
// when the count reaches WAIT_MAX (WAIT_MAX = 0 disables the flag).
//   clk, rst   : clock, synchronous active-high reset
//   clear_i    : FSM is changing state this cycle
//   wait_i     : FSM is in a memory wait state with mem_ready low
//   timeout_o  : count has reached WAIT_MAX (combinational, from the register)
module mem_watchdog #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic wait_i,
   output logic timeout_o
);

   localparam int unsigned CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_SAT = '1;
   localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(WAIT_MAX);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear on any state change; saturate so a disabled watchdog never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (wait_i && (cnt_q != CNT_SAT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_o = (WAIT_MAX > 0) && (cnt_q == LIMIT);

endmodule : mem_watchdog

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: FETCH/DECODE/execute FSM driving datapath
// strobes, with a memory-wait watchdog, retire pulse and retire counter.
//   clk, rst            : clock, synchronous active-high reset
//   opcode              : Instruction[31:26]
//   mem_ready           : unified memory completed current access
//   pc_write ... pc_source : datapath strobes/selects
//   state               : current FSM state code
//   fault               : sticky error flag (FAULT state)
//   instr_done          : one-cycle pulse in the last cycle of an instruction
//   instr_count         : retired-instruction counter (wraps)
module multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                mem_to_reg,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [SEL_W-1:0]    alu_src_b,
   output logic [SEL_W-1:0]    alu_op,
   output logic [SEL_W-1:0]    pc_source,
   output logic [STATE_W-1:0]  state,
   output logic                fault,
   output logic                instr_done,
   output logic [COUNT_W-1:0]  instr_count
);

   state_e             state_q, state_d;
   logic [COUNT_W-1:0] instr_count_q;
   logic               timeout;
   logic               wd_clear;
   logic               wd_wait;
   logic               done_c;
   ctrl_t              ctrl_c;
   ctrl_t              ctrl_gated_c;

   mem_watchdog #(
      .WAIT_MAX (WAIT_MAX)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (wd_clear),
      .wait_i    (wd_wait),
      .timeout_o (timeout)
   );

   assign wd_clear = (state_d != state_q);
   assign wd_wait  = is_mem_wait_state(state_q) && !mem_ready;

   // Next-state logic; in wait states mem_ready takes priority over timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready)    state_d = S_DECODE;
            else if (timeout) state_d = S_FAULT;
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
               default:      state_d = S_FAULT;
            endcase
         end
         S_MEMADR: begin
            if (opcode == OP_LW)      state_d = S_MEMRD;
            else if (opcode == OP_SW) state_d = S_MEMWR;
            else                      state_d = S_FAULT;
         end
         S_MEMRD: begin
            if (mem_ready)    state_d = S_MEMWB;
            else if (timeout) state_d = S_FAULT;
         end
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR: begin
            if (mem_ready)    state_d = S_FETCH;
            else if (timeout) state_d = S_FAULT;
         end
         S_EXEC:   state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_FAULT;
      endcase
   end

   // Per-state datapath controls; everything not named stays 0.
   always_comb begin
      ctrl_c           = '0;
      ctrl_c.alu_src_b = SRCB_RT;
      ctrl_c.alu_op    = ALU_ADD;
      ctrl_c.pc_source = PC_ALU;
      case (state_q)
         S_FETCH: begin
            ctrl_c.mem_read  = 1'b1;
            ctrl_c.alu_src_b = SRCB_FOUR;
            ctrl_c.ir_write  = mem_ready;
            ctrl_c.pc_write  = mem_ready;
         end
         S_DECODE: ctrl_c.alu_src_b = SRCB_IMM_SH2;
         S_MEMADR: begin
            ctrl_c.alu_src_a = 1'b1;
            ctrl_c.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl_c.mem_read = 1'b1;
            ctrl_c.i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            ctrl_c.mem_to_reg = 1'b1;
            ctrl_c.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            ctrl_c.mem_write = 1'b1;
            ctrl_c.i_or_d    = 1'b1;
         end
         S_EXEC: begin
            ctrl_c.alu_src_a = 1'b1;
            ctrl_c.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            ctrl_c.reg_dst   = 1'b1;
            ctrl_c.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl_c.alu_src_a     = 1'b1;
            ctrl_c.alu_op        = ALU_SUB;
            ctrl_c.pc_write_cond = 1'b1;
            ctrl_c.pc_source     = PC_ALUOUT;
         end
         S_JUMP: begin
            ctrl_c.pc_write  = 1'b1;
            ctrl_c.pc_source = PC_JUMP;
         end
         S_ADDIEX: begin
            ctrl_c.alu_src_a = 1'b1;
            ctrl_c.alu_src_b = SRCB_IMM;
         end
         S_ADDIWB: ctrl_c.reg_write = 1'b1;
         default: ;
      endcase
   end

   // Architectural side effects are suppressed while reset is held.
   always_comb begin
      ctrl_gated_c = ctrl_c;
      if (rst) begin
         ctrl_gated_c.pc_write      = 1'b0;
         ctrl_gated_c.pc_write_cond = 1'b0;
         ctrl_gated_c.ir_write      = 1'b0;
         ctrl_gated_c.mem_read      = 1'b0;
         ctrl_gated_c.mem_write     = 1'b0;
         ctrl_gated_c.reg_write     = 1'b0;
      end
   end

   // Retire: last cycle of an instruction is the one heading back to FETCH.
   assign done_c = !rst && (state_d == S_FETCH) && (state_q != S_FETCH);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_FETCH;
         instr_count_q <= '0;
      end else begin
         state_q <= state_d;
         if (done_c) begin
            instr_count_q <= instr_count_q + COUNT_W'(1);
         end
      end
   end

   assign pc_write      = ctrl_gated_c.pc_write;
   assign pc_write_cond = ctrl_gated_c.pc_write_cond;
   assign i_or_d        = ctrl_gated_c.i_or_d;
   assign mem_read      = ctrl_gated_c.mem_read;
   assign mem_write     = ctrl_gated_c.mem_write;
   assign ir_write      = ctrl_gated_c.ir_write;
   assign mem_to_reg    = ctrl_gated_c.mem_to_reg;
   assign reg_dst       = ctrl_gated_c.reg_dst;
   assign reg_write     = ctrl_gated_c.reg_write;
   assign alu_src_a     = ctrl_gated_c.alu_src_a;
   assign alu_src_b     = ctrl_gated_c.alu_src_b;
   assign alu_op        = ctrl_gated_c.alu_op;
   assign pc_source     = ctrl_gated_c.pc_source;
   assign state         = state_q;
   assign fault         = (state_q == S_FAULT);
   assign instr_done    = done_c;
   assign instr_count   = instr_count_q;

endmodule : multicycle_ctrl

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (WAIT_MAX = 15).
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [5:0]  opcode = 6'b0;
   logic        mem_ready = 1'b0;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic [3:0]  state;
   logic        fault, instr_done;
   logic [31:0] instr_count;

   int checks   = 0;
   int failures = 0;

   multicycle_ctrl #(.WAIT_MAX(15)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .state(state), .fault(fault),
      .instr_done(instr_done), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // Quiet reset; returns at a negedge with rst released and FETCH current.
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; mem_ready = 1'b1; opcode = 6'b100011;
      @(posedge clk); #1;
      checks++; if (state !== 4'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state); end
      checks++; if ({pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, instr_done} !== 7'b0) begin
         failures++; $display("FAIL reset_strobes: got %b expected 0000000",
            {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, instr_done}); end
      checks++; if (fault !== 1'b0 || instr_count !== 32'd0) begin failures++;
         $display("FAIL reset_fault_count: got fault=%b count=%0d expected 0/0", fault, instr_count); end
      @(negedge clk);
      rst = 1'b0; mem_ready = 1'b0; #1;
      checks++; if (mem_read !== 1'b1 || alu_src_b !== 2'b01 || ir_write !== 1'b0) begin failures++;
         $display("FAIL fetch_wait_ctrl: got mem_read=%b srcb=%b ir_write=%b expected 1/01/0", mem_read, alu_src_b, ir_write); end
   endtask

   task automatic test_lw();
      logic [3:0] exp [5];
      exp = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      apply_reset();
      opcode = 6'b100011; mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (state !== exp[i]) begin failures++; $display("FAIL lw_state c%0d: got %0d expected %0d", i, state, exp[i]); end
         checks++; if (reg_write !== (i == 4) || instr_done !== (i == 4)) begin failures++;
            $display("FAIL lw_regwr_done c%0d: got %b%b expected %b%b", i, reg_write, instr_done, i == 4, i == 4); end
         if (i == 0) begin
            checks++; if (ir_write !== 1'b1 || pc_write !== 1'b1) begin failures++; $display("FAIL lw_fetch_load: got ir=%b pc=%b expected 1/1", ir_write, pc_write); end
         end
         if (i == 2) begin
            checks++; if (alu_src_a !== 1'b1 || alu_src_b !== 2'b10) begin failures++; $display("FAIL lw_memadr: got a=%b b=%b expected 1/10", alu_src_a, alu_src_b); end
         end
         if (i == 3) begin
            checks++; if (mem_read !== 1'b1 || i_or_d !== 1'b1) begin failures++; $display("FAIL lw_memrd: got rd=%b iord=%b expected 1/1", mem_read, i_or_d); end
         end
         if (i == 4) begin
            checks++; if (mem_to_reg !== 1'b1 || reg_dst !== 1'b0) begin failures++; $display("FAIL lw_memwb: got m2r=%b dst=%b expected 1/0", mem_to_reg, reg_dst); end
         end
         @(negedge clk);
      end
      #1;
      checks++; if (state !== 4'd0 || instr_count !== 32'd1) begin failures++;
         $display("FAIL lw_end: got state=%0d count=%0d expected 0/1", state, instr_count); end
   endtask

   task automatic test_beq_j();
      logic [3:0] exp [3];
      apply_reset();
      mem_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         opcode = (k == 0) ? 6'b000100 : 6'b000010;
         exp = '{4'd0, 4'd1, (k == 0) ? 4'd8 : 4'd9};
         for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (state !== exp[i] || instr_done !== (i == 2)) begin failures++;
               $display("FAIL br_j_state k%0d c%0d: got %0d/%b expected %0d/%b", k, i, state, instr_done, exp[i], i == 2); end
            if (i == 1) begin
               checks++; if (alu_src_b !== 2'b11) begin failures++; $display("FAIL decode_srcb: got %b expected 11", alu_src_b); end
            end
            if (i == 2 && k == 0) begin
               checks++; if (pc_write_cond !== 1'b1 || pc_source !== 2'b01 || alu_op !== 2'b01 || pc_write !== 1'b0) begin failures++;
                  $display("FAIL beq_ctrl: got cond=%b src=%b op=%b pcw=%b expected 1/01/01/0", pc_write_cond, pc_source, alu_op, pc_write); end
            end
            if (i == 2 && k == 1) begin
               checks++; if (pc_write !== 1'b1 || pc_source !== 2'b10 || pc_write_cond !== 1'b0) begin failures++;
                  $display("FAIL j_ctrl: got pcw=%b src=%b cond=%b expected 1/10/0", pc_write, pc_source, pc_write_cond); end
            end
            @(negedge clk);
         end
      end
      #1;
      checks++; if (state !== 4'd0 || instr_count !== 32'd2) begin failures++;
         $display("FAIL br_j_end: got state=%0d count=%0d expected 0/2", state, instr_count); end
   endtask

   task automatic test_addi();
      logic [3:0] exp [4];
      exp = '{4'd0, 4'd1, 4'd10, 4'd11};
      apply_reset();
      opcode = 6'b001000; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (state !== exp[i] || reg_write !== (i == 3) || instr_done !== (i == 3)) begin failures++;
            $display("FAIL addi c%0d: got %0d/%b/%b expected %0d/%b/%b", i, state, reg_write, instr_done, exp[i], i == 3, i == 3); end
         if (i == 2) begin
            checks++; if (alu_src_a !== 1'b1 || alu_src_b !== 2'b10) begin failures++; $display("FAIL addiex_ctrl: got a=%b b=%b expected 1/10", alu_src_a, alu_src_b); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_sw_wait();
      logic [3:0] exp [7];
      exp = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
      apply_reset();
      opcode = 6'b101011;
      for (int i = 0; i < 7; i++) begin
         mem_ready = (i < 3) || (i == 6);
         #1;
         checks++; if (state !== exp[i] || instr_done !== (i == 6) || fault !== 1'b0) begin failures++;
            $display("FAIL sw_wait c%0d: got %0d/%b/%b expected %0d/%b/0", i, state, instr_done, fault, exp[i], i == 6); end
         if (i >= 3) begin
            checks++; if (mem_write !== 1'b1 || i_or_d !== 1'b1 || mem_read !== 1'b0) begin failures++;
               $display("FAIL sw_memwr c%0d: got wr=%b iord=%b rd=%b expected 1/1/0", i, mem_write, i_or_d, mem_read); end
         end
         @(negedge clk);
      end
      #1;
      checks++; if (state !== 4'd0 || fault !== 1'b0 || instr_count !== 32'd1) begin failures++;
         $display("FAIL sw_end: got state=%0d fault=%b count=%0d expected 0/0/1", state, fault, instr_count); end
   endtask

   // Runs straight after test_sw_wait so instr_count starts at 1.
   task automatic test_fetch_timeout();
      opcode = 6'b000010; mem_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         #1;
         checks++; if (state !== 4'd0 || fault !== 1'b0) begin failures++;
            $display("FAIL to_waiting c%0d: got %0d/%b expected 0/0", i, state, fault); end
         @(negedge clk);
      end
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (state !== 4'd15 || fault !== 1'b1 || mem_read !== 1'b0 || instr_done !== 1'b0) begin failures++;
            $display("FAIL to_fault c%0d: got %0d/%b/%b/%b expected 15/1/0/0", i, state, fault, mem_read, instr_done); end
         @(negedge clk);
      end
      #1;
      checks++; if (instr_count !== 32'd1) begin failures++; $display("FAIL to_count: got %0d expected 1", instr_count); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mem_ready = 1'b0; #1;
      checks++; if (state !== 4'd0 || fault !== 1'b0 || instr_count !== 32'd0) begin failures++;
         $display("FAIL to_reset: got %0d/%b/%0d expected 0/0/0", state, fault, instr_count); end
      @(negedge clk);
   endtask

   task automatic test_ready_wins();
      apply_reset();
      opcode = 6'b000010;
      for (int i = 0; i < 16; i++) begin
         mem_ready = (i == 15);
         #1;
         if (i == 15) begin
            checks++; if (state !== 4'd0 || ir_write !== 1'b1) begin failures++;
               $display("FAIL rw_limit: got %0d/%b expected 0/1", state, ir_write); end
         end
         @(negedge clk);
      end
      #1;
      checks++; if (state !== 4'd1 || fault !== 1'b0) begin failures++; $display("FAIL rw_decode: got %0d/%b expected 1/0", state, fault); end
      @(negedge clk); @(negedge clk); #1;
      checks++; if (state !== 4'd0 || instr_count !== 32'd1) begin failures++;
         $display("FAIL rw_end: got %0d/%0d expected 0/1", state, instr_count); end
   endtask

   task automatic test_bad_opcode();
      apply_reset();
      opcode = 6'b000010; mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      opcode = 6'b111111;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++; if (state !== ((i == 0) ? 4'd0 : (i == 1) ? 4'd1 : 4'd15) || instr_done !== 1'b0) begin failures++;
            $display("FAIL bad_op c%0d: got %0d/%b expected %0d/0", i, state, instr_done, (i == 0) ? 0 : (i == 1) ? 1 : 15); end
         @(negedge clk);
      end
      #1;
      checks++; if (instr_count !== 32'd1 || fault !== 1'b1) begin failures++;
         $display("FAIL bad_op_end: got count=%0d fault=%b expected 1/1", instr_count, fault); end
   endtask

   task automatic test_count_wrap();
      logic [3:0] exp [4];
      exp = '{4'd0, 4'd1, 4'd6, 4'd7};
      apply_reset();
      force dut.instr_count_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.instr_count_q;
      #1;
      checks++; if (instr_count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_preload: got %h expected ffffffff", instr_count); end
      opcode = 6'b000000; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (state !== exp[i] || instr_done !== (i == 3)) begin failures++;
            $display("FAIL rtype c%0d: got %0d/%b expected %0d/%b", i, state, instr_done, exp[i], i == 3); end
         if (i == 2) begin
            checks++; if (alu_op !== 2'b10 || alu_src_a !== 1'b1) begin failures++; $display("FAIL exec_ctrl: got op=%b a=%b expected 10/1", alu_op, alu_src_a); end
         end
         if (i == 3) begin
            checks++; if (reg_dst !== 1'b1 || reg_write !== 1'b1 || mem_to_reg !== 1'b0) begin failures++;
               $display("FAIL aluwb_ctrl: got dst=%b wr=%b m2r=%b expected 1/1/0", reg_dst, reg_write, mem_to_reg); end
         end
         @(negedge clk);
      end
      #1;
      checks++; if (instr_count !== 32'd0) begin failures++; $display("FAIL wrap_count: got %h expected 00000000", instr_count); end
   endtask

   initial begin
      #200000;
      $display("FAIL sim_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_lw();
      test_beq_j();
      test_addi();
      test_sw_wait();
      test_fetch_timeout();
      test_ready_wins();
      test_bad_opcode();
      test_count_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_multicycle_ctrl
